alu_seq_unit: RTL and testbench

ALU_SEQ_UNIT -- requirements
Module: alu_seq_unit

---
 rtl/alu_seq_unit.sv | 144 ++++++++++++++
 tb/tb_alu_seq_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_unit.sv
// Sequential multi-cycle ALU: shift-add multiply, restoring divide and
// bit-serial logical shifts, one step per clock.
// Optional feature macro: ALU_SEQ_DIVZ_EN (divide-by-zero short-cut and DIVZ flag).
module alu_seq_unit #(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned CW = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             CLRn,
  input  logic             START,
  input  logic [1:0]       OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic [WIDTH-1:0] HI,
  output logic             DIVZ
);

  localparam int unsigned NW = CW + 1;
  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_DIV = 2'b01;
  localparam logic [1:0] OP_SHL = 2'b10;
  localparam logic [1:0] OP_SHR = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state_q, state_d;
  logic [NW-1:0]    cnt_q;
  logic [NW-1:0]    n_c;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             accept_c, step_c;
  logic [WIDTH:0]   mul_sum_c;
  logic [WIDTH:0]   div_sh_c;
  logic [WIDTH-1:0] div_sub_c;
  logic             div_ge_c;
  logic [WIDTH-1:0] hi_step_c, lo_step_c;

  // Step count for the request on the inputs.
  always_comb begin
    n_c = NW'(WIDTH);
    if (OP[1]) begin
      n_c = NW'(B[CW-1:0]);
    end
`ifdef ALU_SEQ_DIVZ_EN
    else if (OP == OP_DIV && B == '0) begin
      n_c = '0;
    end
`endif
  end

  // Next-state and control decode.
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    step_c   = 1'b0;
    case (state_q)
      IDLE, FIN: begin
        if (START) begin
          accept_c = 1'b1;
          state_d  = (n_c == '0) ? FIN : RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        step_c = 1'b1;
        if (cnt_q == NW'(1)) state_d = FIN;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with registered BUSY/DONE decoded from the next state.
  always_ff @(posedge CLK or negedge CLRn) begin
    if (!CLRn) begin
      state_q <= IDLE;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      state_q <= state_d;
      BUSY    <= (state_d == RUN);
      DONE    <= (state_d == FIN);
    end
  end

  // One iteration of the selected algorithm on the {HI,RESULT} accumulator.
  always_comb begin
    mul_sum_c = {1'b0, HI} + (RESULT[0] ? {1'b0, a_q} : '0);
    div_sh_c  = {HI, RESULT[WIDTH-1]};
    div_ge_c  = (div_sh_c >= {1'b0, b_q});
    div_sub_c = div_sh_c[WIDTH-1:0] - b_q;
    hi_step_c = '0;
    lo_step_c = RESULT;
    case (op_q)
      OP_MUL: begin
        hi_step_c = mul_sum_c[WIDTH:1];
        lo_step_c = {mul_sum_c[0], RESULT[WIDTH-1:1]};
      end
      OP_DIV: begin
        hi_step_c = div_ge_c ? div_sub_c : div_sh_c[WIDTH-1:0];
        lo_step_c = {RESULT[WIDTH-2:0], div_ge_c};
      end
      OP_SHL: lo_step_c = {RESULT[WIDTH-2:0], 1'b0};
      OP_SHR: lo_step_c = {1'b0, RESULT[WIDTH-1:1]};
      default: lo_step_c = RESULT;
    endcase
  end

  // Operand capture on accept, accumulator update on each RUN step.
  always_ff @(posedge CLK or negedge CLRn) begin
    if (!CLRn) begin
      cnt_q  <= '0;
      op_q   <= OP_MUL;
      a_q    <= '0;
      b_q    <= '0;
      RESULT <= '0;
      HI     <= '0;
      DIVZ   <= 1'b0;
    end else if (accept_c) begin
      cnt_q  <= n_c;
      op_q   <= OP;
      a_q    <= A;
      b_q    <= B;
      HI     <= '0;
      DIVZ   <= 1'b0;
      RESULT <= (OP == OP_MUL) ? B : A;
`ifdef ALU_SEQ_DIVZ_EN
      if (OP == OP_DIV && B == '0) begin
        RESULT <= '1;
        HI     <= A;
        DIVZ   <= 1'b1;
      end
`endif
    end else if (step_c) begin
      cnt_q  <= cnt_q - NW'(1);
      HI     <= hi_step_c;
      RESULT <= lo_step_c;
    end
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Bench for alu_seq_unit: directed vector table, reset and wide-operand
// sequences, then randomized operations against an arithmetic reference.
module tb_alu_seq_unit;

  localparam int unsigned W = 8;

  logic         clk;
  logic         clrn;
  logic         start, start16;
  logic [1:0]   op, op16;
  logic [W-1:0] a, b, result, hi;
  logic [15:0]  a16, b16, result16, hi16;
  logic         busy, done, divz;
  logic         busy16, done16, divz16;

  int n_cmp = 0;
  int n_bad = 0;

  alu_seq_unit #(.WIDTH(W)) dut (
    .CLK(clk), .CLRn(clrn), .START(start), .OP(op), .A(a), .B(b),
    .BUSY(busy), .DONE(done), .RESULT(result), .HI(hi), .DIVZ(divz)
  );

  alu_seq_unit #(.WIDTH(16)) dut16 (
    .CLK(clk), .CLRn(clrn), .START(start16), .OP(op16), .A(a16), .B(b16),
    .BUSY(busy16), .DONE(done16), .RESULT(result16), .HI(hi16), .DIVZ(divz16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic [7:0] h;
    bit         d;
    int         n;
    string      name;
  } vec_t;

  vec_t vecs[8];

`ifdef ALU_SEQ_DIVZ_EN
  localparam bit DZ_FLAG = 1'b1;
  localparam int DZ_N    = 0;
`else
  localparam bit DZ_FLAG = 1'b0;
  localparam int DZ_N    = 8;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference behaviour from the arithmetic definition of each operation.
  function automatic void ref_model(input logic [1:0] o, input logic [7:0] av, input logic [7:0] bv,
                                    output logic [7:0] r, output logic [7:0] h,
                                    output bit d, output int n);
    logic [15:0] p;
    d = 1'b0;
    h = 8'h00;
    case (o)
      2'b00: begin p = 16'(av) * 16'(bv); r = p[7:0]; h = p[15:8]; n = 8; end
      2'b01: begin
        if (bv == 8'h00) begin r = 8'hFF; h = av; d = DZ_FLAG; n = DZ_N; end
        else begin r = av / bv; h = av % bv; n = 8; end
      end
      2'b10: begin n = int'(bv % 8); r = av << n; end
      default: begin n = int'(bv % 8); r = av >> n; end
    endcase
  endfunction

  // Issue one request, optionally scribble on inputs while it runs, and
  // check the BUSY/DONE profile and the final values.
  task automatic do_op(input logic [1:0] o, input logic [7:0] av, input logic [7:0] bv, input bit junk,
                       input logic [7:0] er, input logic [7:0] eh, input bit ed, input int en,
                       input string tag);
    int done_at;
    int busy_n;
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    @(posedge clk);
    done_at = -1;
    busy_n  = 0;
    for (int i = 0; i <= en; i++) begin
      if (i > 0) begin
        @(negedge clk);
        if (junk) begin
          start = 1'($urandom % 2); op = 2'($urandom); a = 8'($urandom); b = 8'($urandom);
        end else begin
          start = 1'b0;
        end
        @(posedge clk);
      end
      #1;
      if (busy) busy_n++;
      if (done && done_at < 0) done_at = i;
    end
    start = 1'b0;
    chk({tag, " done_edge"}, 32'(done_at), 32'(en));
    chk({tag, " busy_cycles"}, 32'(busy_n), 32'(en));
    chk({tag, " result"}, 32'(result), 32'(er));
    chk({tag, " hi"}, 32'(hi), 32'(eh));
    chk({tag, " divz"}, 32'(divz), 32'(ed));
  endtask

  initial begin
    logic [7:0] er, eh;
    bit         ed;
    int         en, lat;
    logic [1:0] ro;
    logic [7:0] ra, rb;

    vecs[0] = '{2'b00, 8'd200, 8'd3,   8'h58, 8'h02, 1'b0, 8,     "mul200x3"};
    vecs[1] = '{2'b01, 8'd100, 8'd7,   8'd14, 8'd2,  1'b0, 8,     "div100/7"};
    vecs[2] = '{2'b01, 8'd100, 8'd0,   8'hFF, 8'd100, DZ_FLAG, DZ_N, "div100/0"};
    vecs[3] = '{2'b10, 8'h81,  8'd3,   8'h08, 8'h00, 1'b0, 3,     "shl81by3"};
    vecs[4] = '{2'b11, 8'h81,  8'd0,   8'h81, 8'h00, 1'b0, 0,     "shr81by0"};
    vecs[5] = '{2'b11, 8'h80,  8'h0F,  8'h01, 8'h00, 1'b0, 7,     "shr80by7"};
    vecs[6] = '{2'b00, 8'hFF,  8'hFF,  8'h01, 8'hFE, 1'b0, 8,     "mulffxff"};
    vecs[7] = '{2'b01, 8'd5,   8'd9,   8'd0,  8'd5,  1'b0, 8,     "div5/9"};

    clrn = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    start16 = 1'b0; op16 = 2'b00; a16 = '0; b16 = '0;
    #2;
    chk("reset busy", 32'(busy), 32'(0));
    chk("reset done", 32'(done), 32'(0));
    chk("reset result_hi", 32'({result, hi}), 32'(0));
    chk("reset divz", 32'(divz), 32'(0));
    @(negedge clk); @(negedge clk);
    clrn = 1'b1;

    // Directed table, issued back-to-back (each START lands in the previous FIN).
    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, (i % 2) == 1, vecs[i].r, vecs[i].h,
            vecs[i].d, vecs[i].n, vecs[i].name);
    end

    // Results hold in IDLE after FIN.
    repeat (3) @(posedge clk);
    #1;
    chk("hold result", 32'(result), 32'(8'd0));
    chk("hold hi", 32'(hi), 32'(8'd5));
    chk("idle done", 32'(done), 32'(0));
    chk("idle busy", 32'(busy), 32'(0));

    // Asynchronous clear part way through a multiply.
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 8'd200; b = 8'd3;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 clrn = 1'b0;
    #1;
    chk("abort busy", 32'(busy), 32'(0));
    chk("abort done", 32'(done), 32'(0));
    chk("abort result_hi", 32'({result, hi}), 32'(0));
    chk("abort divz", 32'(divz), 32'(0));
    start = 1'b1; op = 2'b00; a = 8'd5; b = 8'd6;
    repeat (2) @(posedge clk);
    #1;
    chk("start in reset", 32'(busy), 32'(0));
    @(negedge clk);
    clrn = 1'b1;
    @(posedge clk);
    #1;
    chk("first accept", 32'(busy), 32'(1));
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("mul5x6 done", 32'(done), 32'(1));
    chk("mul5x6 result", 32'({hi, result}), 32'(16'd30));

    // Wide multiply on the 16-bit instance.
    @(negedge clk);
    start16 = 1'b1; op16 = 2'b00; a16 = 16'hFFFF; b16 = 16'hFFFF;
    @(posedge clk);
    #1 start16 = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40 && lat < 0; i++) begin
      @(posedge clk);
      #1;
      if (done16) lat = i;
    end
    chk("w16 done_edge", 32'(lat), 32'(16));
    chk("w16 hi", 32'(hi16), 32'(16'hFFFE));
    chk("w16 result", 32'(result16), 32'(16'h0001));
    chk("w16 divz", 32'(divz16), 32'(0));

    // Randomized operations with random input noise during RUN.
    for (int t = 0; t < 150; t++) begin
      ro = 2'($urandom);
      ra = 8'($urandom);
      rb = 8'($urandom);
      if (ro == 2'b01 && ($urandom % 6) == 0) rb = 8'h00;
      if (($urandom % 3) == 0) repeat (1 + $urandom % 2) @(posedge clk);
      ref_model(ro, ra, rb, er, eh, ed, en);
      do_op(ro, ra, rb, 1'($urandom % 2), er, eh, ed, en, $sformatf("rnd%0d", t));
    end

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
